button_input_interface: RTL

//   User-input front end of the recorder; the input-side counterpart of the seven-segment display path.
//   - Synchronises and debounces raw push-buttons.
//   - Produces one-cycle press pulses.
//   - Holds the selected channel number and the record/play mode FSM.
//   - chan drives the segment display's channel number input; rec_en/play_en gate the audio datapath.

---
 rtl/recorder_pkg.sv | 14 +
 rtl/button_debouncer.sv | 55 +++++
 rtl/button_input_interface.sv | 114 +++++++++++
 3 files changed

// File: rtl/recorder_pkg.sv
// Shared types for the recorder user-input front end: mode encoding and button indices.
package recorder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECORD = 2'd1,
    PLAY   = 2'd2
  } mode_t;

  localparam int BTN_CHAN = 0;
  localparam int BTN_REC  = 1;
  localparam int BTN_PLAY = 2;

endpackage

// File: rtl/button_debouncer.sv
// One push-button: 2-flop synchroniser, stability counter, registered rising-edge pulse.
// Latency raw edge -> level = 2 + DEBOUNCE_CYCLES cycles; pulse coincides with level rising.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic pulse
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic             pulse_q, pulse_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The counter only runs while the synced value disagrees with the accepted one,
  // so any bounce back to the accepted level restarts the stability window.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_MAX) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    pulse_d = stable_d & ~stable_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      pulse_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= raw;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      pulse_q  <= pulse_d;
      cnt_q    <= cnt_d;
    end
  end

  assign level = stable_q;
  assign pulse = pulse_q;

endmodule

// File: rtl/button_input_interface.sv
// Recorder input front end: debounced buttons, channel select and IDLE/RECORD/PLAY mode FSM.
// Mode outputs change the cycle after a button pulse; optional long-hold erase under `LONG_PRESS_EN.
module button_input_interface
  import recorder_pkg::*;
#(
  parameter int  NUM_CH          = 2,
  parameter int  DEBOUNCE_CYCLES = 1_000_000,
  parameter int  LONG_CYCLES     = 100_000_000,
  localparam int CH_W            = $clog2(NUM_CH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [2:0]      btn_raw,
  input  logic            play_done,
  output logic [2:0]      btn_level,
  output logic [2:0]      btn_pulse,
  output logic [CH_W-1:0] chan,
  output logic [1:0]      mode,
  output logic            rec_en,
  output logic            play_en,
  output logic            erase_pulse
);

  for (genvar i = 0; i < 3; i++) begin : g_btn
    button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk  (clk),
      .reset(reset),
      .raw  (btn_raw[i]),
      .level(btn_level[i]),
      .pulse(btn_pulse[i])
    );
  end

  mode_t           mode_q, mode_d;
  logic [CH_W-1:0] chan_q, chan_d;
  logic            rec_en_q, play_en_q;

  always_comb begin
    mode_d = mode_q;
    chan_d = chan_q;
    case (mode_q)
      IDLE: begin
        if (btn_pulse[BTN_CHAN]) begin
          chan_d = (chan_q == CH_W'(NUM_CH - 1)) ? '0 : chan_q + 1'b1;
        end
        if (btn_pulse[BTN_REC]) begin
          mode_d = RECORD;
        end else if (btn_pulse[BTN_PLAY]) begin
          mode_d = PLAY;
        end
      end
      RECORD: if (btn_pulse[BTN_REC]) mode_d = IDLE;
      PLAY:   if (btn_pulse[BTN_PLAY] || play_done) mode_d = IDLE;
      default: mode_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q    <= IDLE;
      chan_q    <= '0;
      rec_en_q  <= 1'b0;
      play_en_q <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      chan_q    <= chan_d;
      rec_en_q  <= (mode_d == RECORD);
      play_en_q <= (mode_d == PLAY);
    end
  end

  assign mode    = mode_q;
  assign chan    = chan_q;
  assign rec_en  = rec_en_q;
  assign play_en = play_en_q;

`ifdef LONG_PRESS_EN
  localparam int HOLD_W = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES - 1);

  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              hold_run;
  logic              erase_q, erase_d;

  // Saturating at HOLD_MAX keeps a continued hold from issuing repeat erases.
  always_comb begin
    hold_run = btn_level[BTN_PLAY] && (mode_q == IDLE);
    hold_d   = '0;
    if (hold_run) begin
      hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + 1'b1;
    end
    erase_d = hold_run && (hold_d == HOLD_MAX) && (hold_q != HOLD_MAX);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q  <= '0;
      erase_q <= 1'b0;
    end else begin
      hold_q  <= hold_d;
      erase_q <= erase_d;
    end
  end

  assign erase_pulse = erase_q;
`else
  logic long_cycles_unused;
  assign long_cycles_unused = (LONG_CYCLES > 0);
  assign erase_pulse        = 1'b0;
`endif

endmodule
